// File: rtl/if_fetch_pkg.sv
// Shared constants, bus types and FSM encoding for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam inst_t ZERO_WORD  = '0;
    localparam logic  STOP       = 1'b1;
    localparam logic  NO_STOP    = 1'b0;
    localparam logic  RST_ENABLE = 1'b0;

    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, EXCP} fetch_state_e;

    function automatic logic is_misaligned(input addr_t a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, handshaked ROM port, hold buffer, delay-slot redirects, flush drain.
// Optional misaligned-fetch trap enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stallreq_if_o,
    output logic        if_excp_o
);

    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        hold_pc_q, hold_pc_d;
    inst_t        hold_inst_q, hold_inst_d;
    logic         redir_vld_q, redir_vld_d;
    addr_t        redir_tgt_q, redir_tgt_d;
    addr_t        drain_addr_q, drain_addr_d;
    addr_t        next_pc;
    logic         advance;
    logic [4:0]   stall_unused;

    assign stall_unused = stall[5:1];

`ifdef IF_MISALIGN_CHECK_EN
    logic excp_wait_q, excp_wait_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            hold_pc_q    <= '0;
            hold_inst_q  <= '0;
            redir_vld_q  <= 1'b0;
            redir_tgt_q  <= '0;
            drain_addr_q <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            excp_wait_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            redir_vld_q  <= redir_vld_d;
            redir_tgt_q  <= redir_tgt_d;
            drain_addr_q <= drain_addr_d;
`ifdef IF_MISALIGN_CHECK_EN
            excp_wait_q  <= excp_wait_d;
`endif
        end
    end

    // A branch seen in the advance cycle itself is newer than any pending one.
    always_comb begin
        if (branch_flag_i)    next_pc = branch_target_i;
        else if (redir_vld_q) next_pc = redir_tgt_q;
        else                  next_pc = pc_q + 32'd4;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_pc_d     = hold_pc_q;
        hold_inst_d   = hold_inst_q;
        redir_vld_d   = redir_vld_q;
        redir_tgt_d   = redir_tgt_q;
        drain_addr_d  = drain_addr_q;
`ifdef IF_MISALIGN_CHECK_EN
        excp_wait_d   = excp_wait_q;
`endif
        advance       = 1'b0;
        rom_req_o     = 1'b0;
        rom_addr_o    = pc_q;
        if_pc_o       = ZERO_WORD;
        if_inst_o     = ZERO_WORD;
        stallreq_if_o = 1'b0;
        if_excp_o     = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef IF_MISALIGN_CHECK_EN
                state_d = excp_wait_q ? IDLE : REQ;
`else
                state_d = REQ;
`endif
            end
            REQ: begin
                rom_req_o = 1'b1;
                if (rom_ack_i) begin
                    if_inst_o = rom_data_i;
                    if_pc_o   = pc_q;
                    if (stall[0] == NO_STOP) begin
                        advance = 1'b1;
                    end else begin
                        hold_pc_d   = pc_q;
                        hold_inst_d = rom_data_i;
                        state_d     = HOLD;
                    end
                end else begin
                    stallreq_if_o = 1'b1;
                end
            end
            HOLD: begin
                if_inst_o = hold_inst_q;
                if_pc_o   = hold_pc_q;
                if (stall[0] == NO_STOP) advance = 1'b1;
            end
            DRAIN: begin
                rom_req_o     = 1'b1;
                rom_addr_o    = drain_addr_q;
                stallreq_if_o = 1'b1;
                if (rom_ack_i) state_d = REQ;
            end
`ifdef IF_MISALIGN_CHECK_EN
            EXCP: begin
                if_pc_o   = pc_q;
                if_excp_o = 1'b1;
                if (stall[0] == NO_STOP) begin
                    state_d     = IDLE;
                    excp_wait_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (advance) begin
            pc_d        = next_pc;
            redir_vld_d = 1'b0;
            state_d     = REQ;
`ifdef IF_MISALIGN_CHECK_EN
            if (is_misaligned(next_pc)) state_d = EXCP;
`endif
        end else if (branch_flag_i) begin
            redir_vld_d = 1'b1;
            redir_tgt_d = branch_target_i;
        end

        // Flush overrides everything; an unanswered request must still be drained.
        if (flush_i) begin
            pc_d        = new_pc_i;
            redir_vld_d = 1'b0;
            hold_pc_d   = '0;
            hold_inst_d = '0;
            if_inst_o   = ZERO_WORD;
            if_pc_o     = ZERO_WORD;
            if_excp_o   = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            excp_wait_d = 1'b0;
`endif
            if ((state_q == REQ || state_q == DRAIN) && !rom_ack_i) begin
                state_d = DRAIN;
                if (state_q == REQ) drain_addr_d = pc_q;
            end else begin
                state_d = REQ;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, reset/misalign sequences, randomized run vs. a stream-level model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_ack_i;
    logic [31:0] rom_data_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_if_o;
    logic        if_excp_o;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .rom_req_o       (rom_req_o),
        .rom_addr_o      (rom_addr_o),
        .rom_ack_i       (rom_ack_i),
        .rom_data_i      (rom_data_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .stallreq_if_o   (stallreq_if_o),
        .if_excp_o       (if_excp_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0001;
    endfunction

    typedef struct {
        logic        s0, ak;
        logic [31:0] data;
        logic        br;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] npc;
        logic        ereq;
        logic [31:0] eaddr, einst, epc;
        logic        estall;
    } vec_t;

    function automatic vec_t mk(input logic s0, input logic ak, input logic [31:0] d,
                                input logic b, input logic [31:0] t, input logic f,
                                input logic [31:0] n, input logic er, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] ep, input logic es);
        vec_t v;
        v.s0 = s0; v.ak = ak; v.data = d; v.br = b; v.tgt = t; v.fl = f; v.npc = n;
        v.ereq = er; v.eaddr = ea; v.einst = ei; v.epc = ep; v.estall = es;
        return v;
    endfunction

    task automatic drive_idle();
        stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0; rom_ack_i = 1'b0; rom_data_i = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    localparam int NV = 22;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    vec_t vecs [NV];

    logic        have, pend_v, outst, discard, first;
    logic [31:0] exp_pc, pend, out_addr;
    int          deliveries;

    initial begin
        vecs[0]  = mk(0,0,DB,          0,0,0,0,            0,32'h0,0,0,0);
        vecs[1]  = mk(0,1,32'h0,       0,0,0,0,            1,32'h0,32'h0,32'h0,0);
        vecs[2]  = mk(0,0,DB,          0,0,0,0,            1,32'h4,0,0,1);
        vecs[3]  = mk(0,0,DB,          0,0,0,0,            1,32'h4,0,0,1);
        vecs[4]  = mk(0,1,32'h4,       0,0,0,0,            1,32'h4,32'h4,32'h4,0);
        vecs[5]  = mk(0,1,32'h8,       0,0,0,0,            1,32'h8,32'h8,32'h8,0);
        vecs[6]  = mk(1,1,32'h2402000A,0,0,0,0,            1,32'hC,32'h2402000A,32'hC,0);
        vecs[7]  = mk(1,0,DB,          0,0,0,0,            0,32'hC,32'h2402000A,32'hC,0);
        vecs[8]  = mk(0,0,DB,          0,0,0,0,            0,32'hC,32'h2402000A,32'hC,0);
        vecs[9]  = mk(0,1,32'h10,      0,0,0,0,            1,32'h10,32'h10,32'h10,0);
        vecs[10] = mk(0,0,DB,          0,0,1,32'h20,       1,32'h14,0,0,1);
        vecs[11] = mk(0,0,DB,          0,0,0,0,            1,32'h14,0,0,1);
        vecs[12] = mk(0,1,32'h14,      0,0,0,0,            1,32'h14,0,0,1);
        vecs[13] = mk(0,1,32'h20,      1,32'h100,0,0,      1,32'h20,32'h20,32'h20,0);
        vecs[14] = mk(0,0,DB,          1,32'h200,0,0,      1,32'h100,0,0,1);
        vecs[15] = mk(0,1,32'h100,     0,0,0,0,            1,32'h100,32'h100,32'h100,0);
        vecs[16] = mk(0,1,32'h200,     0,0,0,0,            1,32'h200,32'h200,32'h200,0);
        vecs[17] = mk(0,1,32'h204,     0,0,1,32'hFFFF_FFFC,1,32'h204,0,0,0);
        vecs[18] = mk(0,1,32'hFFFF_FFFC,0,0,0,0,           1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'hFFFF_FFFC,0);
        vecs[19] = mk(0,0,DB,          0,0,0,0,            1,32'h0,0,0,1);
        vecs[20] = mk(0,1,32'h0,       0,0,0,0,            1,32'h0,0,0,0);
        vecs[21] = mk(0,0,DB,          0,0,0,0,            1,32'h4,0,0,1);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            stall           = {5'b0, vecs[i].s0};
            rom_ack_i       = vecs[i].ak;
            rom_data_i      = vecs[i].data;
            branch_flag_i   = vecs[i].br;
            branch_target_i = vecs[i].tgt;
            flush_i         = vecs[i].fl;
            new_pc_i        = vecs[i].npc;
            #1;
            chk($sformatf("v%0d.req", i),   {31'b0, rom_req_o},     {31'b0, vecs[i].ereq});
            if (vecs[i].ereq || i == 0 || i == 7 || i == 8)
                chk($sformatf("v%0d.addr", i), rom_addr_o, vecs[i].eaddr);
            chk($sformatf("v%0d.inst", i),  if_inst_o,              vecs[i].einst);
            chk($sformatf("v%0d.pc", i),    if_pc_o,                vecs[i].epc);
            chk($sformatf("v%0d.stall", i), {31'b0, stallreq_if_o}, {31'b0, vecs[i].estall});
            chk($sformatf("v%0d.excp", i),  {31'b0, if_excp_o},     32'h0);
            @(negedge clk);
        end

        // Asynchronous reset while a fetch of 0x4 is still waiting.
        drive_idle();
        #1;
        chk("midwait.req_before", {31'b0, rom_req_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("rst.req",   {31'b0, rom_req_o},     32'h0);
        chk("rst.addr",  rom_addr_o,             32'h0);
        chk("rst.inst",  if_inst_o,              32'h0);
        chk("rst.pc",    if_pc_o,                32'h0);
        chk("rst.stall", {31'b0, stallreq_if_o}, 32'h0);
        chk("rst.excp",  {31'b0, if_excp_o},     32'h0);

`ifdef IF_MISALIGN_CHECK_EN
        do_reset();
        @(negedge clk);
        rom_ack_i = 1'b1; rom_data_i = 32'h11; branch_flag_i = 1'b1; branch_target_i = 32'h102;
        #1;
        chk("mis.deliver", if_inst_o, 32'h11);
        @(negedge clk);
        drive_idle();
        #1;
        chk("mis.excp",   {31'b0, if_excp_o}, 32'h1);
        chk("mis.pc",     if_pc_o,            32'h102);
        chk("mis.inst",   if_inst_o,          32'h0);
        chk("mis.noreq",  {31'b0, rom_req_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("mis.excp_once", {31'b0, if_excp_o}, 32'h0);
        chk("mis.wait_req",  {31'b0, rom_req_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("mis.wait_req2", {31'b0, rom_req_o}, 32'h0);
        flush_i = 1'b1; new_pc_i = 32'h40;
        @(negedge clk);
        drive_idle();
        #1;
        chk("mis.flush_req",  {31'b0, rom_req_o}, 32'h1);
        chk("mis.flush_addr", rom_addr_o,         32'h40);
`endif

        // Randomized run against a fetch-stream model.
        do_reset();
        have = 1'b0; pend_v = 1'b0; outst = 1'b0; discard = 1'b0; first = 1'b1;
        exp_pc = 32'h0; pend = '0; out_addr = '0; deliveries = 0;
        for (int c = 0; c < 4000; c++) begin
            logic        s0, br, fl, ak, exp_req, exp_have, es;
            logic [31:0] tgt, npc, exp_addr, ei, ep;
            s0  = ($urandom_range(3) == 0);
            br  = ($urandom_range(7) == 0);
            tgt = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            fl  = ($urandom_range(39) == 0);
            npc = $urandom & 32'h0000_0FFC;
            ak  = rom_req_o && ($urandom_range(2) != 0);
            stall = {5'($urandom_range(31)), s0};
            branch_flag_i = br; branch_target_i = tgt;
            flush_i = fl; new_pc_i = npc;
            rom_ack_i = ak; rom_data_i = memf(rom_addr_o);
            #1;
            exp_req  = !first && !have;
            exp_addr = outst ? out_addr : exp_pc;
            exp_have = have || (ak && !discard);
            if (fl || !exp_have) begin ei = '0; ep = '0; end
            else begin ei = memf(exp_pc); ep = exp_pc; end
            es = exp_req && (!ak || discard);

            chk($sformatf("r%0d.req", c),   {31'b0, rom_req_o},     {31'b0, exp_req});
            if (exp_req) chk($sformatf("r%0d.addr", c), rom_addr_o, exp_addr);
            chk($sformatf("r%0d.inst", c),  if_inst_o,              ei);
            chk($sformatf("r%0d.pc", c),    if_pc_o,                ep);
            chk($sformatf("r%0d.stall", c), {31'b0, stallreq_if_o}, {31'b0, es});
            chk($sformatf("r%0d.excp", c),  {31'b0, if_excp_o},     32'h0);

            if (fl) begin
                exp_pc  = npc;
                pend_v  = 1'b0;
                have    = 1'b0;
                discard = exp_req && !ak;
            end else begin
                if (discard && ak) discard = 1'b0;
                else have = exp_have;
                if (have && !s0) begin
                    exp_pc = br ? tgt : (pend_v ? pend : exp_pc + 32'd4);
                    pend_v = 1'b0;
                    have   = 1'b0;
                    deliveries++;
                end else if (br) begin
                    pend_v = 1'b1;
                    pend   = tgt;
                end
            end
            if (exp_req && !ak) begin
                outst    = 1'b1;
                out_addr = exp_addr;
            end else if (ak) begin
                outst = 1'b0;
            end
            first = 1'b0;
            @(negedge clk);
        end
        chk("random.progress", {31'b0, deliveries > 200}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that owns the program counter and drives the handshaked instruction-memory port. It delivers one instruction and its PC per accepted fetch to the IF/ID pipeline register. It applies delay-slot branch redirects from ID and exception flushes from the control unit, and raises a stall request while memory has not answered. A one-entry hold buffer keeps a fetched instruction if the pipeline is stalled when memory returns it.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- stall  in  6  pipeline stall vector from ctrl; bit 0 = this stage, bit 1 = IF/ID
- branch_flag_i  in  1  ID resolved a taken branch/jump
- branch_target_i  in  32  redirect target
- flush_i  in  1  exception flush from ctrl
- new_pc_i  in  32  exception handler address, valid with flush_i
- rom_req_o  out  1  fetch request
- rom_addr_o  out  32  fetch address; stable while rom_req_o=1 and rom_ack_i=0
- rom_ack_i  in  1  memory accepts request; rom_data_i valid in the same cycle
- rom_data_i  in  32  instruction word
- if_pc_o  out  32  PC of presented instruction, to IF/ID
- if_inst_o  out  32  presented instruction (ZeroWord = bubble), to IF/ID
- stallreq_if_o  out  1  fetch-not-ready stall request to ctrl
- if_excp_o  out  1  misaligned-fetch exception (see Configuration)

## Operation
- FSM states: IDLE, REQ, HOLD, DRAIN. Reset state is IDLE. Registers pc=RESET_PC, hold buffer empty, redirect pending cleared.
- IDLE: rom_req_o=0. Go to REQ next cycle unconditionally.
- REQ: rom_req_o=1 and rom_addr_o=pc.
  - Without ack: stallreq_if_o=1, and if_inst_o/if_pc_o = ZeroWord.
  - With ack: if_inst_o=rom_data_i and if_pc_o=pc, combinationally.
    - If stall[0]=NoStop this is an advance: pc<=next_pc, stay in REQ.
    - Otherwise capture {pc, rom_data_i} into the hold buffer and go to HOLD.
- HOLD: rom_req_o=0, stallreq_if_o=0, outputs driven from the hold buffer. The first cycle with stall[0]=NoStop is an advance: pc<=next_pc, go to REQ.
- next_pc: the redirect target if a redirect is pending or branch_flag_i=1 in the advance cycle; otherwise pc+4 (32-bit wrap, 0xFFFF_FFFC+4=0). The instruction at the current pc is the delay slot and is always delivered.
- branch_flag_i asserted in a non-advance cycle: latch the target as pending redirect. A later branch_flag_i overwrites it. Cleared on advance.
- flush_i has priority over branch and advance:
  - pc<=new_pc_i; pending redirect and hold buffer cleared; if_inst_o=ZeroWord in the flush cycle.
  - In REQ without ack: go to DRAIN.
  - Otherwise (REQ with ack, HOLD, IDLE): go to REQ.
- DRAIN: rom_req_o=1 at the old address, stallreq_if_o=1, outputs ZeroWord. On ack, discard the data and go to REQ. A second flush during DRAIN updates pc only.
- Asynchronous reset mid-operation: all state and outputs return to reset values immediately. An outstanding memory request is abandoned.

## Timing
- Zero-wait memory (ack same cycle as req): one instruction per cycle. rom_addr_o advances every cycle.
- Fetch latency = cycles from req to ack. stallreq_if_o is high in every waiting cycle and low in the ack cycle.
- IF/ID latches if_inst_o/if_pc_o at the end of the ack or HOLD-release cycle.
- Redirect visible on rom_addr_o the cycle after the advance edge.
- Reset values: rom_req_o=0, rom_addr_o=RESET_PC, if_pc_o=0, if_inst_o=0, stallreq_if_o=0, if_excp_o=0.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A next_pc with bits[1:0]≠0 is not requested.
  - The stage presents if_inst_o=ZeroWord, if_pc_o=bad address, if_excp_o=1 for one cycle (HOLD semantics if stalled). It then waits in IDLE for flush_i.
- Undefined: if_excp_o tied 0. Low address bits are forwarded unchanged to rom_addr_o.

## Structure
- Shared Defines.v holds ZeroWord, InstBus, InstAddrBus, Stop/NoStop, and the active-low reset level constant.
- FSM state encodings for if_fetch also go in Defines.v.
- No sub-module. The hold buffer and redirect register are small and stay inline.

## Test plan
- Release reset, ack tied 1, rom_data=addr -> rom_addr_o 0x0,0x4,0x8 on consecutive cycles; if_inst_o equals them; stallreq_if_o=0.
- Ack for 0x4 delayed 2 cycles -> rom_addr_o held 0x4, stallreq_if_o=1 and if_inst_o=0 for 2 cycles, then 0x4 delivered.
- branch_flag_i=1, target 0x100, while fetching 0x8 -> 0x8 delivered, next rom_addr_o=0x100.
- stall[0]=Stop in ack cycle of 0xC with data 0x2402000A -> if_inst_o holds 0x2402000A, no request issued; release -> rom_addr_o=0x10.
- flush_i with new_pc_i=0x20 while 0x14 is outstanding -> DRAIN with stallreq_if_o=1; 0x14 data discarded; next request at 0x20.
- rst low mid-wait -> all outputs at reset values immediately. With IF_MISALIGN_CHECK_EN, target 0x102 -> if_excp_o=1, if_pc_o=0x102, no request issued.
